// File: rtl/vdc_signals_h.sv
// -----------------------------------------------------------------------------
// vdc_signals_h -- horizontal timing generator for the VDC.
//
// Counts pixels within a character cell (pix) and character columns within a
// scanline (col), advancing only on dot-clock enable cycles. Decodes the
// per-line event strobes used by the vertical stage and generates the
// horizontal sync pulse and the horizontal visible window.
//
// Parameters
//   DISP_DELAY   column at which the display window opens (from column 0)
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   enable       dot-clock enable; all state advances only when high
//   reg_ht       R0, horizontal total minus 1, in columns
//   reg_hd       R1, horizontal displayed, in columns
//   reg_hp       R2, horizontal sync position, in columns
//   reg_hw       R3[3:0], horizontal sync width in columns (0 means 16)
//   reg_cth      R22[7:4], character total horizontal minus 1, in pixels
//   lineStart    strobe: col=0, pix=0
//   lineEnd      strobe: last pixel of the line
//   displayStart strobe: col=DISP_DELAY, pix=0
//   half1End     strobe: last pixel of the first half-line
//   half2Start   strobe: first pixel of the second half-line
//   hSyncStart   strobe: col=reg_hp, pix=0
//   vSyncStart   [0] full-line vsync point, [1] half-line vsync point
//   hsync        horizontal sync output
//   hVisible     inside the horizontal display window
//   col          current column
//   pix          current pixel within the column
//
// Strobes and counters are registered together: on an enable edge the
// counters move to their next position and the strobes load the decode of
// that same position, so both are visible one enable after the position is
// computed and hold until the following enable.
// -----------------------------------------------------------------------------
module vdc_signals_h #(
    parameter int unsigned DISP_DELAY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] reg_ht,
    input  logic [7:0] reg_hd,
    input  logic [7:0] reg_hp,
    input  logic [3:0] reg_hw,
    input  logic [3:0] reg_cth,
    output logic       lineStart,
    output logic       lineEnd,
    output logic       displayStart,
    output logic       half1End,
    output logic       half2Start,
    output logic       hSyncStart,
    output logic [1:0] vSyncStart,
    output logic       hsync,
    output logic       hVisible,
    output logic [7:0] col,
    output logic [3:0] pix
);

    localparam logic [8:0] DISP_COL = 9'(DISP_DELAY);

    // After reset the counters wait in PRESTART so that the first enable
    // lands on col=0, pix=0 and produces a clean lineStart.
    typedef enum logic {
        H_PRESTART,
        H_RUN
    } h_state_t;

    h_state_t   state;
    logic [7:0] ht_s;       // line total, frozen for the duration of a line
    logic [3:0] cth_s;      // character total, frozen for the duration of a line
    logic [4:0] hs_cnt;     // remaining sync columns

    // Next-position and decode signals.
    logic       col_wrap;
    logic       line_wrap;
    logic [7:0] nxt_col;
    logic [3:0] nxt_pix;
    logic [7:0] nxt_ht_s;
    logic [3:0] nxt_cth_s;
    logic       nxt_pix_first;
    logic       nxt_pix_last;
    logic [7:0] half_col;
    logic [8:0] vs_half_sum;
    logic [8:0] line_cols;
    logic [8:0] vs_half_col;
    logic [8:0] hvis_end_col;
    logic       dec_line_start;
    logic       dec_line_end;
    logic       dec_disp_start;
    logic       dec_half1_end;
    logic       dec_half2_start;
    logic       dec_hsync_start;
    logic       dec_vs_half;
    logic       dec_hvis_end;
    logic       nxt_hvis;
    logic [4:0] nxt_hs_cnt;

    // -------------------------------------------------------------------------
    // Next counter position and its decode. Decodes use the shadow totals that
    // will be in force at the new position, so the first position of a line
    // already sees the freshly loaded totals.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path through this
        // block leaves a value unassigned and infers a latch.
        col_wrap        = 1'b0;
        line_wrap       = 1'b0;
        nxt_col         = col;
        nxt_pix         = pix;
        nxt_ht_s        = ht_s;
        nxt_cth_s       = cth_s;
        nxt_hvis        = hVisible;
        nxt_hs_cnt      = hs_cnt;

        if (state == H_RUN) begin
            col_wrap  = (pix == cth_s);
            line_wrap = col_wrap && (col == ht_s);
        end

        if (state == H_PRESTART || line_wrap) begin
            nxt_col = 8'd0;
            nxt_pix = 4'd0;
        end else if (col_wrap) begin
            nxt_col = col + 8'd1;
            nxt_pix = 4'd0;
        end else begin
            nxt_pix = pix + 4'd1;
        end

        // Totals are sampled only when a line wraps, never mid-line.
        if (line_wrap) begin
            nxt_ht_s  = reg_ht;
            nxt_cth_s = reg_cth;
        end

        nxt_pix_first = (nxt_pix == 4'd0);
        nxt_pix_last  = (nxt_pix == nxt_cth_s);
        half_col      = nxt_ht_s >> 1;

        // Half-line vsync column: reg_hp shifted by half a line, folded back
        // into the line with a single conditional subtract.
        vs_half_sum = {1'b0, reg_hp} + {1'b0, half_col} + 9'd1;
        line_cols   = {1'b0, nxt_ht_s} + 9'd1;
        vs_half_col = (vs_half_sum >= line_cols) ? (vs_half_sum - line_cols) : vs_half_sum;

        hvis_end_col = DISP_COL + {1'b0, reg_hd};

        // Columns never exceed the line total, so any decode whose target
        // column lies beyond it simply never matches.
        dec_line_start  = (nxt_col == 8'd0) && nxt_pix_first;
        dec_line_end    = (nxt_col == nxt_ht_s) && nxt_pix_last;
        dec_disp_start  = ({1'b0, nxt_col} == DISP_COL) && nxt_pix_first;
        dec_half1_end   = (nxt_col == half_col) && nxt_pix_last;
        dec_half2_start = ({1'b0, nxt_col} == ({1'b0, half_col} + 9'd1)) && nxt_pix_first;
        dec_hsync_start = (nxt_col == reg_hp) && nxt_pix_first;
        dec_vs_half     = ({1'b0, nxt_col} == vs_half_col) && nxt_pix_first;
        dec_hvis_end    = ({1'b0, nxt_col} == hvis_end_col) && nxt_pix_first;

        // Window end wins over window start so reg_hd=0 never opens it;
        // window start wins over the line-start clear so a zero delay works.
        if (dec_hvis_end) begin
            nxt_hvis = 1'b0;
        end else if (dec_disp_start) begin
            nxt_hvis = 1'b1;
        end else if (dec_line_start) begin
            nxt_hvis = 1'b0;
        end

        // Sync width is counted in columns; a new sync start restarts it even
        // if the previous pulse is still running. The count is unaffected by
        // the line wrap, so a late sync carries into the next line.
        if (dec_hsync_start) begin
            nxt_hs_cnt = {~|reg_hw, reg_hw};
        end else if (col_wrap && (hs_cnt != 5'd0)) begin
            nxt_hs_cnt = hs_cnt - 5'd1;
        end
    end

    // -------------------------------------------------------------------------
    // State registers: counters, shadows, strobes and window/sync state all
    // move together on enable edges only.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state        <= H_PRESTART;
            col          <= 8'd0;
            pix          <= 4'd0;
            ht_s         <= reg_ht;
            cth_s        <= reg_cth;
            hs_cnt       <= 5'd0;
            hVisible     <= 1'b0;
            lineStart    <= 1'b0;
            lineEnd      <= 1'b0;
            displayStart <= 1'b0;
            half1End     <= 1'b0;
            half2Start   <= 1'b0;
            hSyncStart   <= 1'b0;
            vSyncStart   <= 2'b00;
        end else if (enable) begin
            state        <= H_RUN;
            col          <= nxt_col;
            pix          <= nxt_pix;
            ht_s         <= nxt_ht_s;
            cth_s        <= nxt_cth_s;
            hs_cnt       <= nxt_hs_cnt;
            hVisible     <= nxt_hvis;
            lineStart    <= dec_line_start;
            lineEnd      <= dec_line_end;
            displayStart <= dec_disp_start;
            half1End     <= dec_half1_end;
            half2Start   <= dec_half2_start;
            hSyncStart   <= dec_hsync_start;
            vSyncStart   <= {dec_vs_half, dec_hsync_start};
        end
    end

    assign hsync = (hs_cnt != 5'd0);

endmodule

// File: tb/tb_vdc_signals_h.sv
// -----------------------------------------------------------------------------
// tb_vdc_signals_h -- self-checking bench for vdc_signals_h.
//
// A positional model tracks the enable count within the current line and
// derives column, pixel, strobes, sync and window from that count with plain
// arithmetic. A compare process checks every DUT output against it on each
// falling clock edge; directed scenarios pin the model with hand-computed
// event positions from a per-enable log of the DUT outputs.
// -----------------------------------------------------------------------------
module tb_vdc_signals_h;

    localparam int DD = 1;

    localparam int F_LS  = 0;
    localparam int F_LE  = 1;
    localparam int F_DS  = 2;
    localparam int F_H1E = 3;
    localparam int F_H2S = 4;
    localparam int F_HSS = 5;
    localparam int F_VS0 = 6;
    localparam int F_VS1 = 7;
    localparam int F_HS  = 8;
    localparam int F_HV  = 9;

    logic       clk    = 1'b0;
    logic       reset  = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] reg_ht = 8'd0;
    logic [7:0] reg_hd = 8'd0;
    logic [7:0] reg_hp = 8'd0;
    logic [3:0] reg_hw = 4'd0;
    logic [3:0] reg_cth = 4'd0;

    logic       lineStart, lineEnd, displayStart, half1End, half2Start, hSyncStart;
    logic [1:0] vSyncStart;
    logic       hsync, hVisible;
    logic [7:0] col;
    logic [3:0] pix;

    vdc_signals_h #(.DISP_DELAY(DD)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .reg_ht       (reg_ht),
        .reg_hd       (reg_hd),
        .reg_hp       (reg_hp),
        .reg_hw       (reg_hw),
        .reg_cth      (reg_cth),
        .lineStart    (lineStart),
        .lineEnd      (lineEnd),
        .displayStart (displayStart),
        .half1End     (half1End),
        .half2Start   (half2Start),
        .hSyncStart   (hSyncStart),
        .vSyncStart   (vSyncStart),
        .hsync        (hsync),
        .hVisible     (hVisible),
        .col          (col),
        .pix          (pix)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] col;
        logic [3:0] pix;
        logic       ls, le, ds, h1e, h2s, hss;
        logic [1:0] vs;
        logic       hs, hv;
    } snap_t;

    snap_t log_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    ls_clks = 0;
    int    le_clks = 0;
    int    hs_clks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic snap_t dut_snap();
        snap_t s;
        s.col = col;
        s.pix = pix;
        s.ls  = lineStart;
        s.le  = lineEnd;
        s.ds  = displayStart;
        s.h1e = half1End;
        s.h2s = half2Start;
        s.hss = hSyncStart;
        s.vs  = vSyncStart;
        s.hs  = hsync;
        s.hv  = hVisible;
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model: position = enable count k within the line.
    // ------------------------------------------------------------------
    bit   m_valid   = 1'b0;
    bit   m_run     = 1'b0;
    bit   m_en_edge = 1'b0;
    int   m_k, m_ht, m_cth;
    int   abs_col, sync_start, sync_w;
    bit   sync_act;
    snap_t exp_s = '0;

    always @(posedge clk) begin
        int c, p, h;
        m_en_edge = 1'b0;
        if (reset) begin
            m_valid  = 1'b1;
            m_run    = 1'b0;
            m_k      = 0;
            m_ht     = int'(reg_ht);
            m_cth    = int'(reg_cth);
            abs_col  = 0;
            sync_act = 1'b0;
            exp_s    = '0;
        end else if (enable && m_valid) begin
            m_en_edge = 1'b1;
            if (!m_run) begin
                m_run = 1'b1;
                m_k   = 0;
            end else if (m_k + 1 == (m_ht + 1) * (m_cth + 1)) begin
                m_k   = 0;
                m_ht  = int'(reg_ht);
                m_cth = int'(reg_cth);
            end else begin
                m_k++;
            end
            c = m_k / (m_cth + 1);
            p = m_k % (m_cth + 1);
            h = int'(reg_hp) + m_ht / 2 + 1;
            if (h >= m_ht + 1) h -= m_ht + 1;
            exp_s.col = 8'(c);
            exp_s.pix = 4'(p);
            exp_s.ls  = (m_k == 0);
            exp_s.le  = (m_k == (m_ht + 1) * (m_cth + 1) - 1);
            exp_s.ds  = (c == DD) && (p == 0);
            exp_s.h1e = (c == m_ht / 2) && (p == m_cth);
            exp_s.h2s = (c == m_ht / 2 + 1) && (p == 0);
            exp_s.hss = (c == int'(reg_hp)) && (p == 0);
            exp_s.vs  = {(c == h) && (p == 0), exp_s.hss};
            if (p == 0) abs_col++;
            if (exp_s.hss) begin
                sync_act   = 1'b1;
                sync_start = abs_col;
                sync_w     = (reg_hw == 4'd0) ? 16 : int'(reg_hw);
            end
            exp_s.hs = sync_act && ((abs_col - sync_start) < sync_w);
            exp_s.hv = (c >= DD) && (c < DD + int'(reg_hd));
        end
    end

    // Compare process: every output, every cycle, once the model is live.
    always @(negedge clk) begin
        if (m_valid) begin
            snap_t d;
            d = dut_snap();
            check("cmp_col",     32'(d.col), 32'(exp_s.col));
            check("cmp_pix",     32'(d.pix), 32'(exp_s.pix));
            check("cmp_strobes", 32'({d.ls, d.le, d.ds, d.h1e, d.h2s, d.hss, d.vs}),
                                 32'({exp_s.ls, exp_s.le, exp_s.ds, exp_s.h1e, exp_s.h2s, exp_s.hss, exp_s.vs}));
            check("cmp_hsync",   32'(d.hs), 32'(exp_s.hs));
            check("cmp_hvisible", 32'(d.hv), 32'(exp_s.hv));
        end
    end

    // Per-enable log of DUT outputs plus clock-level hold counters.
    always @(negedge clk) begin
        if (m_en_edge) log_q.push_back(dut_snap());
        if (lineStart === 1'b1) ls_clks++;
        if (lineEnd === 1'b1)   le_clks++;
        if (hsync === 1'b1)     hs_clks++;
    end

    // ------------------------------------------------------------------
    // Log helpers
    // ------------------------------------------------------------------
    function automatic snap_t at(input int i);
        if (i >= 0 && i < log_q.size()) return log_q[i];
        return '0;
    endfunction

    function automatic logic fld(input snap_t s, input int f);
        case (f)
            F_LS:    return s.ls;
            F_LE:    return s.le;
            F_DS:    return s.ds;
            F_H1E:   return s.h1e;
            F_H2S:   return s.h2s;
            F_HSS:   return s.hss;
            F_VS0:   return s.vs[0];
            F_VS1:   return s.vs[1];
            F_HS:    return s.hs;
            default: return s.hv;
        endcase
    endfunction

    function automatic int first_idx(input int f);
        for (int i = 0; i < log_q.size(); i++)
            if (fld(log_q[i], f) === 1'b1) return i;
        return -1;
    endfunction

    function automatic int count(input int f, input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++)
            if (fld(at(i), f) === 1'b1) n++;
        return n;
    endfunction

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic set_regs(input int ht, input int cth, input int hp, input int hw, input int hd);
        reg_ht  = 8'(ht);
        reg_cth = 4'(cth);
        reg_hp  = 8'(hp);
        reg_hw  = 4'(hw);
        reg_hd  = 8'(hd);
    endtask

    task automatic clear_log();
        log_q.delete();
        ls_clks = 0;
        le_clks = 0;
        hs_clks = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        clear_log();
    endtask

    // n enables, one every 'period' clocks.
    task automatic run(input int n, input int period);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            enable = 1'b1;
            for (int j = 1; j < period; j++) begin
                @(negedge clk);
                enable = 1'b0;
            end
        end
        @(negedge clk);
        enable = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- Baseline line: ht=7 cth=1 hp=5 hw=2 hd=4 ----
        set_regs(7, 1, 5, 2, 4);
        repeat (2) @(negedge clk);
        do_reset();
        check("reset_outputs", 32'(dut_snap()), 0);
        run(33, 1);
        check("t1_ls_first",   32'(first_idx(F_LS)), 0);
        check("t1_ls_17",      32'(at(16).ls), 1);
        check("t1_ls_count",   32'(count(F_LS, 0, 32)), 3);
        check("t1_le_idx",     32'(first_idx(F_LE)), 15);
        check("t1_le_col",     32'(at(15).col), 7);
        check("t1_h1e_idx",    32'(first_idx(F_H1E)), 7);
        check("t1_h1e_pos",    32'({at(7).col, at(7).pix}), 32'({8'd3, 4'd1}));
        check("t1_h2s_idx",    32'(first_idx(F_H2S)), 8);
        check("t1_h2s_col",    32'(at(8).col), 4);
        check("t1_hsync_idx",  32'(first_idx(F_HS)), 10);
        check("t1_hsync_col",  32'(at(10).col), 5);
        check("t1_hsync_len",  32'(count(F_HS, 0, 15)), 4);
        check("t1_vs0_idx",    32'(first_idx(F_VS0)), 10);
        check("t1_vs1_idx",    32'(first_idx(F_VS1)), 2);
        check("t1_vs1_col",    32'(at(2).col), 1);
        check("t1_ds_idx",     32'(first_idx(F_DS)), 2);
        check("t1_hvis_len",   32'(count(F_HV, 0, 15)), 8);
        check("t1_hvis_col4",  32'(at(9).hv), 1);
        check("t1_hvis_col5",  32'(at(10).hv), 0);

        // ---- Wide window: hd=10 runs to line end ----
        reg_hd = 8'd10;
        clear_log();
        run(16, 1);
        check("t2_hvis_len",   32'(count(F_HV, 0, 15)), 14);
        check("t2_hvis_col7",  32'(at(14).hv), 1);
        check("t2_ls_clear",   32'({at(15).ls, at(15).hv}), 32'(2'b10));

        // ---- Mid-line total change takes effect next line ----
        clear_log();
        run(4, 1);
        reg_ht = 8'd3;
        run(12, 1);
        run(8, 1);
        check("t3_le_idx",     32'(first_idx(F_LE)), 14);
        check("t3_le_col",     32'(at(14).col), 7);
        check("t3_ls_new",     32'(at(15).ls), 1);
        check("t3_short_le",   32'({at(22).le, at(22).col}), 32'({1'b1, 8'd3}));
        check("t3_short_ls",   32'(at(23).ls), 1);
        check("t3_ls_count",   32'(count(F_LS, 0, 23)), 2);

        // ---- hw=0 (16 columns) spanning the wrap, cth=0 ----
        set_regs(31, 0, 24, 0, 4);
        do_reset();
        run(64, 1);
        check("t4_hsync_len",  32'(count(F_HS, 0, 47)), 16);
        check("t4_hsync_pre",  32'(at(23).hs), 0);
        check("t4_hsync_on",   32'(at(24).hs), 1);
        check("t4_le_ls_adj",  32'({at(31).le, at(32).ls}), 32'(2'b11));
        check("t4_hsync_wrap", 32'(at(32).hs), 1);
        check("t4_hsync_last", 32'(at(39).hs), 1);
        check("t4_hsync_off",  32'(at(40).hs), 0);

        // ---- Enable one clock in three ----
        set_regs(7, 1, 5, 2, 4);
        do_reset();
        run(16, 3);
        check("t5_enables",    32'(log_q.size()), 16);
        check("t5_ls_first",   32'(first_idx(F_LS)), 0);
        check("t5_le_idx",     32'(first_idx(F_LE)), 15);
        check("t5_h1e_idx",    32'(first_idx(F_H1E)), 7);
        check("t5_vs1_idx",    32'(first_idx(F_VS1)), 2);
        check("t5_hsync_len",  32'(count(F_HS, 0, 15)), 4);
        check("t5_ls_clks",    32'(ls_clks), 3);
        check("t5_le_clks",    32'(le_clks), 3);
        check("t5_hs_clks",    32'(hs_clks), 12);

        // ---- Reset in the middle of a line ----
        do_reset();
        run(9, 1);
        check("t6_pos",        32'({at(8).col, at(8).pix}), 32'({8'd4, 4'd0}));
        @(negedge clk);
        reset  = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        check("t6_reset_outs", 32'(dut_snap()), 0);
        reset  = 1'b0;
        enable = 1'b0;
        #1;
        clear_log();
        run(1, 1);
        check("t6_first",      32'({at(0).ls, at(0).le, at(0).col, at(0).pix}),
                               32'({1'b1, 1'b0, 8'd0, 4'd0}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vdc_signals_h.md
# vdc_signals_h

Horizontal timing generator for the VDC. Counts pixels within a character cell and character columns within a scanline, driven by the dot-clock enable. Decodes the per-line event strobes consumed by the vertical signal stage: line start/end, display start, half-line boundaries, horizontal sync start, and full/half-line vsync start points. Also produces the horizontal sync output, the horizontal visible window and the current column.

## Interface
- DISP_DELAY, 1: column at which the display window opens, counted from column 0.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- enable  in  1  dot-clock enable; all state advances only on enable cycles
- reg_ht  in  8  R0, horizontal total (minus 1), in columns
- reg_hd  in  8  R1, horizontal displayed, in columns
- reg_hp  in  8  R2, horizontal sync position, in columns
- reg_hw  in  4  R3[3:0], horizontal sync width in columns; 0 means 16
- reg_cth  in  4  R22[7:4], character total horizontal (minus 1), in pixels
- lineStart, lineEnd, displayStart, half1End, half2Start, hSyncStart  out  1 each  event strobes
- vSyncStart  out  2  [0] = full-line vsync point, [1] = half-line vsync point
- hsync  out  1  horizontal sync
- hVisible  out  1  inside the horizontal display window
- col  out  8  current column
- pix  out  4  current pixel within the column

## Operation
- **Counters**
  - Each enable cycle, `pix` increments. When `pix` equals `cth_s` it wraps to 0 and `col` increments.
  - When `col` equals `ht_s` and `pix` equals `cth_s`, both wrap to 0 (new line).
- **Shadowing**
  - `ht_s` and `cth_s` are shadow copies of `reg_ht` and `reg_cth`, loaded only on the enable cycle that wraps the line. Totals therefore never change mid-line.
  - All other registers are read live.
- **Strobe decodes** (each on the position named):
  - lineStart: col=0, pix=0.
  - lineEnd: col=ht_s, pix=cth_s.
  - displayStart: col=DISP_DELAY, pix=0.
  - half1End: col=ht_s>>1, pix=cth_s.
  - half2Start: col=(ht_s>>1)+1, pix=0.
  - hSyncStart: col=reg_hp, pix=0.
  - vSyncStart[0]: same position as hSyncStart.
  - vSyncStart[1]: col=H, pix=0, where H = (reg_hp + (ht_s>>1) + 1) mod (ht_s+1). Compute H in 9 bits, then subtract ht_s+1 once if the result is ≥ ht_s+1.
  - A decode whose column is > ht_s never fires.
- **Strobe registers**
  - Strobes are registered and reloaded only on enable cycles, with the decode of the new counter position.
  - They are stable between enables, so a consumer qualifying with `enable` sees each strobe exactly once per line.
- **hsync**
  - An internal 5-bit down-counter loads {~|reg_hw, reg_hw} on the hSyncStart position and decrements on each column wrap (pix=cth_s). hsync = counter≠0.
  - Sync continues across the line wrap.
  - A new hSyncStart while the counter is still running reloads it.
- **hVisible**
  - Set on the displayStart position. Cleared at column DISP_DELAY+reg_hd, pix=0 (9-bit compare), or on lineStart, whichever comes first.
  - reg_hd=0: the window never opens.
- **Degenerate totals**
  - reg_cth=0: one pixel per column; lineEnd and lineStart occur on consecutive enables.
  - reg_ht=0: single-column line; half1End coincides with lineEnd, and half2Start never fires.

## Timing
- **Reset**
  - All outputs are 0, `ht_s`/`cth_s` load the current registers, and the hsync counter is 0.
  - Counters sit in a pre-start state. The first enable after reset moves them to col=0, pix=0 and asserts lineStart.
  - Reset mid-line discards the line; there is no partial lineEnd.
- **Latency:** one enable cycle from a counter position to its strobe being visible. Strobes stay high until the next enable, then clear, unless the next position decodes the same strobe.
- **enable low:** counters, strobes and hsync hold.
- **Line length:** exactly (ht_s+1)·(cth_s+1) enables, lineStart to lineStart.
- **Simultaneous positions:** all coincident strobes assert together. For example, with reg_hp=0, hSyncStart and lineStart occur on the same cycle.

## Test plan
- ht=7, cth=1, hp=5, hw=2, hd=4, DISP_DELAY=1, enable always high, after reset:
  - lineStart at enable 1 and 17; lineEnd at enable 16.
  - half1End at col 3 pix 1; half2Start at col 4 pix 0.
  - hsync high for 4 enables starting at col 5.
  - vSyncStart[1] at col 1 ((5+3+1) mod 8).
- Same setup, hVisible high for cols 1–4 (8 enables). Then with hd=10 it stays high through col 7 and clears at lineStart.
- Write reg_ht=3 mid-line: the current line still ends at col 7, and the next line is 8 enables long.
- hw=0 with ht=31: hsync lasts 16 columns and spans the line wrap when hp=24.
- enable toggling 1-of-3: the strobe sequence and counts are identical to the always-on run. Each strobe is held for exactly 3 clks.
- Assert reset at col 4: outputs are 0 next clk, and the first subsequent enable gives lineStart with col=0.
